// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared types and constants for the AES block-stream controller.
package aes_stream_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT, PUSH} state_t;
    localparam int BLK_W = 128;
    localparam int KEY_128 = 128;
    localparam int KEY_192 = 192;
    localparam int KEY_256 = 256;
    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;
endpackage

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: DEPTH-entry result FIFO of {last, data}; DEPTH must be a power of two.
module aes_blk_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 129
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_e, pop_e;
    assign push_e = push & ~full;
    assign pop_e = pop & ~empty;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_e);
            rd_ptr <= rd_ptr + AW'(pop_e);
            count <= count + (AW+1)'(push_e) - (AW+1)'(pop_e);
        end
    end
    always_ff @(posedge clk)
        if (push_e) mem[wr_ptr] <= din;
endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: sequences ECB/CBC block streams through an iterative aes_core with a buffered output.
// Define AES_STREAM_BLKCNT_EN to add the saturating blk_count output.
module aes_stream_ctrl
    import aes_stream_pkg::*;
#(
    parameter int K = 128,
    parameter int INV = 2,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [K-1:0]      key,
    input  logic              key_load,
    input  logic [BLK_W-1:0]  iv,
    input  logic              cbc,
    input  logic              dir,
    input  logic              in_valid,
    input  logic [BLK_W-1:0]  in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              core_start,
    output logic              core_dir,
    output logic [K-1:0]      core_key,
    output logic [BLK_W-1:0]  core_in,
    input  logic              core_done,
    input  logic [BLK_W-1:0]  core_out,
    output logic              out_valid,
    output logic [BLK_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
`ifdef AES_STREAM_BLKCNT_EN
    , output logic [15:0]     blk_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic INV_DIR = (INV == 1) ? DEC : ENC;
    generate
        if (!(K == KEY_128 || K == KEY_192 || K == KEY_256)) begin : g_bad_k
            $error("aes_stream_ctrl: K must be 128, 192 or 256");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("aes_stream_ctrl: DEPTH must be a power of two >= 2");
        end
    endgenerate
    state_t state, nxt;
    logic [K-1:0] key_r;
    logic [BLK_W-1:0] chain, blk_r, ct_r, res_r;
    logic cbc_r, dir_r, first_blk, last_r;
    logic acc, ld_key, push, fifo_full, fifo_empty, dir_sel, eff_cbc, eff_dir, done_w;
    logic [BLK_W-1:0] eff_chain;
    logic [CW-1:0] fifo_count;
    logic [BLK_W:0] fifo_dout;
    assign acc = in_valid & in_ready;
    assign ld_key = key_load & (state == IDLE);
    assign done_w = (state == WAIT) & core_done;
    assign dir_sel = (INV == 2) ? dir : INV_DIR;
    assign eff_cbc = first_blk ? cbc : cbc_r;
    assign eff_dir = first_blk ? dir_sel : dir_r;
    assign eff_chain = first_blk ? iv : chain;
    always_ff @(posedge clk)
        state <= !reset_n ? IDLE : nxt;
    always_comb
        nxt = (state == IDLE)  ? (acc ? START : IDLE) :
              (state == START) ? WAIT :
              (state == WAIT)  ? (core_done ? PUSH : WAIT) : IDLE;
    always_comb begin
        in_ready = reset_n & (state == IDLE) & ~key_load & (fifo_count < CW'(DEPTH));
        core_start = state == START;
        push = (state == PUSH) & ~fifo_full;
        busy = (state != IDLE) | ~first_blk;
    end
    // Message context: chaining value follows ciphertext in both directions.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            first_blk <= 1'b1;
            chain <= '0;
            key_r <= '0;
            cbc_r <= 1'b0;
            dir_r <= ENC;
        end else begin
            if (ld_key) key_r <= key;
            if (acc) first_blk <= in_last;
            if (acc && first_blk) begin
                cbc_r <= cbc;
                dir_r <= dir_sel;
                chain <= iv;
            end
            if (done_w) chain <= (dir_r == DEC) ? ct_r : core_out;
        end
    end
    always_ff @(posedge clk) begin
        if (acc) begin
            blk_r <= (eff_dir == ENC && eff_cbc) ? in_data ^ eff_chain : in_data;
            ct_r <= in_data;
            last_r <= in_last;
        end
        if (done_w) res_r <= (dir_r == DEC && cbc_r) ? core_out ^ chain : core_out;
    end
`ifdef AES_STREAM_BLKCNT_EN
    always_ff @(posedge clk)
        blk_count <= (!reset_n || ld_key) ? 16'h0 : (push && blk_count != 16'hFFFF) ? blk_count + 16'h1 : blk_count;
`endif
    aes_blk_fifo #(.DEPTH(DEPTH), .W(BLK_W + 1)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .pop(out_ready),
        .din({last_r, res_r}),
        .dout(fifo_dout),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );
    assign out_valid = ~fifo_empty;
    assign out_data = fifo_dout[BLK_W-1:0];
    assign out_last = fifo_dout[BLK_W];
    assign core_dir = dir_r;
    assign core_key = key_r;
    assign core_in = blk_r;
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: scoreboard bench for aes_stream_ctrl with a table-driven aes_core stand-in.
module tb_aes_stream_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n, key_load, cbc, dir, in_valid, in_last, in_ready, core_start, core_dir;
    logic core_done, out_valid, out_last, out_ready, busy;
    logic [127:0] key, iv, in_data, core_key, core_in, core_out, out_data;
`ifdef AES_STREAM_BLKCNT_EN
    logic [15:0] blk_count;
`endif
    aes_stream_ctrl #(.K(128), .INV(2), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .key(key), .key_load(key_load), .iv(iv), .cbc(cbc),
        .dir(dir), .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .core_start(core_start), .core_dir(core_dir), .core_key(core_key), .core_in(core_in),
        .core_done(core_done), .core_out(core_out), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy)
`ifdef AES_STREAM_BLKCNT_EN
        , .blk_count(blk_count)
`endif
    );
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] KT = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] KA = 128'h11111111222222223333333344444444;
    localparam logic [127:0] KB = 128'hcafef00dcafef00dcafef00dcafef00d;
    localparam logic [127:0] DK = 128'h0123456789abcdeffedcba9876543210;
    int n_cmp = 0, n_bad = 0, core_lat = 2;
    logic [128:0] sb[$];
    logic [127:0] tk[3], ti[3], to[3];
    logic [127:0] m_in, m_key;
    logic m_dir;
    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Known AES pairs answer by lookup; anything else gets a key-xor stand-in.
    function automatic logic [127:0] aes_model(logic d, logic [127:0] k, logic [127:0] x);
        for (int i = 0; i < 3; i++) begin
            if (!d && k == tk[i] && x == ti[i]) return to[i];
            if (d && k == tk[i] && x == to[i]) return ti[i];
        end
        return x ^ k;
    endfunction
    initial begin
        core_done = 1'b0;
        core_out = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                m_in = core_in;
                m_dir = core_dir;
                m_key = core_key;
                repeat (core_lat) @(negedge clk);
                core_done = 1'b1;
                core_out = aes_model(m_dir, m_key, m_in);
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end
    always @(negedge clk) begin
        logic [128:0] exp;
        #2;
        if (out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out: got %h expected no output", {out_last, out_data});
            end else begin
                exp = sb.pop_front();
                if ({out_last, out_data} !== exp) begin
                    n_bad++;
                    $display("FAIL out_block: got last=%b data=%h expected last=%b data=%h",
                             out_last, out_data, exp[128], exp[127:0]);
                end
            end
        end
    end
    task automatic load_key(logic [127:0] k);
        key = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask
    task automatic send(logic [127:0] d, logic l, logic c, logic dr, logic [127:0] v,
                        logic [127:0] e, bit exp_en);
        in_data = d; in_last = l; cbc = c; dir = dr; iv = v; in_valid = 1'b1;
        for (int n = 0; ; n++) begin
            #2;
            if (in_ready) break;
            if (n == 300) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (exp_en) sb.push_back({l, e});
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && !busy && !out_valid) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got pending=%0d busy=%b expected 0 0", sb.size(), busy);
    endtask
    task automatic wait_not_busy();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            #2;
            if (!busy) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL busy_timeout: got busy=1 expected 0");
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
    initial begin
        logic [127:0] d;
        tk[0] = K1; ti[0] = P0;      to[0] = C0;
        tk[1] = K2; ti[1] = P1 ^ IV; to[1] = C1;
        tk[2] = K2; ti[2] = P2 ^ C1; to[2] = C2;
        reset_n = 1'b0; key = '0; key_load = 1'b0; iv = '0; cbc = 1'b0; dir = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_core_start", 128'(core_start), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load_key(K1);
        send(P0, 1'b1, 1'b0, 1'b0, '0, C0, 1);
        wait_idle();
        chk("ecb_busy_after", 128'(busy), 128'(0));
        load_key(K2);
        send(P1, 1'b0, 1'b1, 1'b0, IV, C1, 1);
        send(P2, 1'b1, 1'b1, 1'b0, IV, C2, 1);
        wait_idle();
        send(C1, 1'b0, 1'b1, 1'b1, IV, P1, 1);
        send(C2, 1'b1, 1'b1, 1'b1, IV, P2, 1);
        wait_idle();
        // Four results fill the buffer while the consumer stalls.
        out_ready = 1'b0;
        load_key(KT);
        for (int i = 0; i < 4; i++) begin
            d = {32'(i), 96'h5a5a5a5a_a5a5a5a5_3c3c3c3c};
            send(d, 1'b1, 1'b0, 1'b0, '0, d ^ KT, 1);
        end
        wait_not_busy();
        repeat (2) @(negedge clk);
        #2;
        chk("bp_in_ready_full", 128'(in_ready), 128'(0));
        chk("bp_out_valid_full", 128'(out_valid), 128'(1));
        fork
            begin
                for (int i = 4; i < 6; i++) begin
                    d = {32'(i), 96'h5a5a5a5a_a5a5a5a5_3c3c3c3c};
                    send(d, 1'b1, 1'b0, 1'b0, '0, d ^ KT, 1);
                end
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_idle();
        load_key(KA);
        @(negedge clk);
        key = KB; key_load = 1'b1; in_data = DK; in_last = 1'b1; cbc = 1'b0; dir = 1'b0; in_valid = 1'b1;
        #2;
        chk("kl_in_ready_blocked", 128'(in_ready), 128'(0));
        @(negedge clk);
        key_load = 1'b0;
        sb.push_back({1'b1, DK ^ KB});
        #2;
        chk("kl_in_ready_next", 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        // Abort an open CBC message mid-core; the late core_done must vanish.
        core_lat = 4;
        load_key(K2);
        send(P2, 1'b0, 1'b1, 1'b0, 128'hdeadbeef_deadbeef_deadbeef_deadbeef, '0, 0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        repeat (6) @(negedge clk);
        #2;
        chk("stray_done_out_valid", 128'(out_valid), 128'(0));
        chk("stray_done_busy", 128'(busy), 128'(0));
        core_lat = 2;
        @(negedge clk);
        load_key(K2);
        send(P1, 1'b1, 1'b1, 1'b0, IV, C1, 1);
        wait_idle();
        chk("sb_empty_end", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
